// File: rtl/tl_rx_cpl_read_ctrl_mc.sv
// Completion read controller: round-robin arbitration over per-VC completion
// buffers, streaming one completion at a time as valid/ready beats.
module tl_rx_cpl_read_ctrl_mc #(
    parameter int unsigned NUM_VC    = 2,
    parameter int unsigned BEAT_DW   = 32,
    parameter int unsigned ENTRY_DW  = 8,
    parameter int unsigned LEN_WIDTH = 10,
    localparam int unsigned VLD_W    = $clog2(BEAT_DW),
    localparam int unsigned INC_W    = $clog2(BEAT_DW / ENTRY_DW) + 1,
    localparam int unsigned VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_n_rst,
    input  logic [NUM_VC-1:0]           i_vc_hdr_empty,
    input  logic [NUM_VC-1:0]           i_vc_data_empty,
    input  logic [NUM_VC-1:0]           i_vc_fmt_data,
    input  logic [NUM_VC*LEN_WIDTH-1:0] i_vc_length,
    output logic [VC_W-1:0]             o_vc_sel,
    output logic [NUM_VC-1:0]           o_vc_hdr_inc,
    output logic [NUM_VC-1:0]           o_vc_data_inc,
    output logic [INC_W-1:0]            o_data_inc_value,
    input  logic                        i_slave_ready,
    output logic                        o_slave_cpl_valid,
    output logic [VLD_W-1:0]            o_slave_cpl_valid_data,
    output logic                        o_slave_cpl_first,
    output logic                        o_slave_cpl_last
);

    localparam int unsigned BCNT_W = LEN_WIDTH - VLD_W + 1;
    localparam int unsigned ENT_SH = $clog2(ENTRY_DW);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q, state_d;
    logic [VC_W-1:0]      vc_q, vc_d;
    logic                 fmt_q, fmt_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [VLD_W-1:0]     rem_q, rem_d;
    logic                 first_q, first_d;
    logic [VC_W-1:0]      rr_q, rr_d;

    logic [NUM_VC-1:0]    elig;
    logic                 any_elig;
    logic [VC_W-1:0]      gnt_vc;
    logic [VC_W-1:0]      idx;
    logic [LEN_WIDTH-1:0] len_arr [NUM_VC];
    logic [LEN_WIDTH-1:0] len_sel;
    logic [LEN_WIDTH-1:0] len_m1;
    logic                 last_c;
    logic [VLD_W-1:0]     vd_c;

    // Unpack the flattened per-VC length bus
    always_comb begin
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            len_arr[i] = i_vc_length[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    // Round-robin pick: first eligible VC at or after the pointer
    always_comb begin
        elig     = ~i_vc_hdr_empty & (~i_vc_fmt_data | ~i_vc_data_empty);
        any_elig = 1'b0;
        gnt_vc   = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            idx = VC_W'((32'(rr_q) + i) % NUM_VC);
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                gnt_vc   = idx;
            end
        end
    end

    // State and latched completion context
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            state_q <= IDLE;
            vc_q    <= '0;
            fmt_q   <= 1'b0;
            bcnt_q  <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            vc_q    <= vc_d;
            fmt_q   <= fmt_d;
            bcnt_q  <= bcnt_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            rr_q    <= rr_d;
        end
    end

    // Next state: grant in IDLE, count accepted beats in SEND
    always_comb begin
        state_d = state_q;
        vc_d    = vc_q;
        fmt_d   = fmt_q;
        bcnt_d  = bcnt_q;
        rem_d   = rem_q;
        first_d = first_q;
        rr_d    = rr_q;
        len_sel = len_arr[gnt_vc];
        // Length 0 encodes 2^LEN_WIDTH DW; the modulo wrap of len-1 handles it
        len_m1  = len_sel - LEN_WIDTH'(1);
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d = SEND;
                    vc_d    = gnt_vc;
                    fmt_d   = i_vc_fmt_data[gnt_vc];
                    bcnt_d  = i_vc_fmt_data[gnt_vc] ? BCNT_W'(len_m1 >> VLD_W) : '0;
                    rem_d   = len_sel[VLD_W-1:0];
                    first_d = 1'b1;
                    rr_d    = (32'(gnt_vc) >= NUM_VC - 1) ? '0 : VC_W'(gnt_vc + 1'b1);
                end
            end
            SEND: begin
                if (i_slave_ready) begin
                    first_d = 1'b0;
                    if (bcnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        bcnt_d = bcnt_q - BCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat outputs and same-cycle pointer increments on accepted beats
    always_comb begin
        o_slave_cpl_valid      = 1'b0;
        o_slave_cpl_first      = 1'b0;
        o_slave_cpl_last       = 1'b0;
        o_slave_cpl_valid_data = '0;
        o_vc_hdr_inc           = '0;
        o_vc_data_inc          = '0;
        o_data_inc_value       = '0;
        o_vc_sel               = vc_q;
        last_c                 = (bcnt_q == '0);
        vd_c                   = '0;
        if (state_q == SEND) begin
            if (!fmt_q) begin
                vd_c = '0;
            end else if (!last_c) begin
                vd_c = '1;
            end else begin
                // A zero remainder wraps to all ones, i.e. a full last beat
                vd_c = rem_q - VLD_W'(1);
            end
            o_slave_cpl_valid      = 1'b1;
            o_slave_cpl_first      = first_q;
            o_slave_cpl_last       = last_c;
            o_slave_cpl_valid_data = vd_c;
            if (i_slave_ready) begin
                if (fmt_q) begin
                    o_vc_data_inc    = NUM_VC'(1) << vc_q;
                    o_data_inc_value = INC_W'(vd_c >> ENT_SH) + INC_W'(1);
                end
                if (last_c) begin
                    o_vc_hdr_inc = NUM_VC'(1) << vc_q;
                end
            end
        end
    end

endmodule
